// File: rtl/lsu_load_align_queue.sv
// lsu_load_align_queue: load-response alignment queue for the LSU.
// Each accepted memory response has its byte lane(s) selected from the raw
// cache word, right-justified and zero/sign-extended, then is queued with its
// writeback tag. The head entry is presented to the writeback arbiter one
// cycle after enqueue with no combinational path from rsp_* to wb_*.
// Optional feature: define LSU_MISALIGN_DETECT_EN to store and report a
// misalign flag on wb_misalign; otherwise wb_misalign is tied low.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BYTESOFWORD
`define BYTESOFWORD 4
`endif

module lsu_load_align_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rsp_valid,
  output logic                      rsp_ready,
  input  logic [`XLEN-1:0]          rsp_data,
  input  logic [1:0]                rsp_offset,
  input  logic [1:0]                rsp_size,
  input  logic                      rsp_is_uint,
  input  logic [TAG_W-1:0]          rsp_tag,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [`XLEN-1:0]          wb_data,
  output logic [TAG_W-1:0]          wb_tag,
  output logic                      wb_misalign,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Byte-lane mask for a load; anything not naturally aligned selects the full word.
  function automatic logic [`BYTESOFWORD-1:0] calc_mask(input logic [1:0] size,
                                                        input logic [1:0] offset);
    logic [`BYTESOFWORD-1:0] m;
    case (size)
      2'd0:    m = 4'b0001 << offset;
      2'd1: begin
        if (offset == 2'd0) begin
          m = 4'h3;
        end else if (offset == 2'd2) begin
          m = 4'hc;
        end else begin
          m = 4'hf;
        end
      end
      2'd2:    m = 4'hf;
      default: m = 4'hf;
    endcase
    return m;
  endfunction

  // Extend an 8-bit field to XLEN; fill with the field's top bit unless unsigned.
  function automatic logic [`XLEN-1:0] ext8(input logic [7:0] f, input logic is_uint);
    return {{(`XLEN-8){~is_uint & f[7]}}, f};
  endfunction

  // Extend a 16-bit field to XLEN; fill with the field's top bit unless unsigned.
  function automatic logic [`XLEN-1:0] ext16(input logic [15:0] f, input logic is_uint);
    return {{(`XLEN-16){~is_uint & f[15]}}, f};
  endfunction

  // Select the masked field and right-justify it; a full mask passes the word through.
  function automatic logic [`XLEN-1:0] extract(input logic [`XLEN-1:0] data,
                                               input logic [`BYTESOFWORD-1:0] mask,
                                               input logic is_uint);
    logic [`XLEN-1:0] r;
    case (mask)
      4'h1:    r = ext8(data[7:0], is_uint);
      4'h2:    r = ext8(data[15:8], is_uint);
      4'h4:    r = ext8(data[23:16], is_uint);
      4'h8:    r = ext8(data[31:24], is_uint);
      4'h3:    r = ext16(data[15:0], is_uint);
      4'hc:    r = ext16(data[31:16], is_uint);
      default: r = data;
    endcase
    return r;
  endfunction

`ifdef LSU_MISALIGN_DETECT_EN
  // A load is misaligned when it is a half at an odd offset, a word off offset 0, or reserved size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic r;
    case (size)
      2'd0:    r = 1'b0;
      2'd1:    r = offset[0];
      2'd2:    r = (offset != 2'd0);
      default: r = 1'b1;
    endcase
    return r;
  endfunction
`endif

  logic [`XLEN-1:0]         data_mem_r [DEPTH];
  logic [TAG_W-1:0]         tag_mem_r  [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [CNT_W-1:0]         count_r;
  logic                     rsp_fire_s;
  logic                     wb_fire_s;
  logic [`BYTESOFWORD-1:0]  enq_mask_s;
  logic [`XLEN-1:0]         enq_data_s;

  assign rsp_ready  = (count_r != FULL_CNT);
  assign wb_valid   = (count_r != {CNT_W{1'b0}});
  assign rsp_fire_s = rsp_valid && rsp_ready;
  assign wb_fire_s  = wb_valid && wb_ready;
  assign count      = count_r;
  assign wb_data    = data_mem_r[rd_ptr_r];
  assign wb_tag     = tag_mem_r[rd_ptr_r];

  // Compute the aligned, extended value of the incoming response.
  always_comb begin
    enq_mask_s = calc_mask(rsp_size, rsp_offset);
    enq_data_s = extract(rsp_data, enq_mask_s, rsp_is_uint);
  end

  // Queue control: pointers and occupancy; reset discards all entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (rsp_fire_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (wb_fire_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({rsp_fire_s, wb_fire_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage: written on accepted responses only, never reset.
  always_ff @(posedge clk) begin
    if (rsp_fire_s && !rst) begin
      data_mem_r[wr_ptr_r] <= enq_data_s;
      tag_mem_r[wr_ptr_r]  <= rsp_tag;
    end
  end

`ifdef LSU_MISALIGN_DETECT_EN
  logic mis_mem_r [DEPTH];

  // Misalign flag storage, written alongside the data entry.
  always_ff @(posedge clk) begin
    if (rsp_fire_s && !rst) begin
      mis_mem_r[wr_ptr_r] <= is_misaligned(rsp_size, rsp_offset);
    end
  end

  assign wb_misalign = mis_mem_r[rd_ptr_r];
`else
  assign wb_misalign = 1'b0;
`endif

endmodule
